// File: rtl/bcd_conv_seq_if.sv
// Handshake bundle for bcd_conv_seq: binary input side and packed BCD result side.
// out_blank only exists when BCD_BLANK_EN is defined.
interface bcd_conv_seq_if #(
   parameter int DATA_W = 20,
   parameter int DIGITS = 6
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_W-1:0]     in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   out_bcd;
   logic                  out_ovf;
`ifdef BCD_BLANK_EN
   logic [DIGITS-1:0]     out_blank;

   modport master (output in_valid, in_data, out_ready,
                   input  in_ready, out_valid, out_bcd, out_ovf, out_blank);
   modport slave  (input  in_valid, in_data, out_ready,
                   output in_ready, out_valid, out_bcd, out_ovf, out_blank);
`else
   modport master (output in_valid, in_data, out_ready,
                   input  in_ready, out_valid, out_bcd, out_ovf);
   modport slave  (input  in_valid, in_data, out_ready,
                   output in_ready, out_valid, out_bcd, out_ovf);
`endif
endinterface

// File: rtl/bcd_conv_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Optional leading-zero blanking output when BCD_BLANK_EN is defined.
//
// state | meaning
// IDLE  | in_ready high, waiting for in_valid
// SHIFT | add-3 correction and shift, DATA_W cycles
// DONE  | result presented, waiting for out_ready
module bcd_conv_seq #(
   parameter int DATA_W = 20,
   parameter int DIGITS = 6
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   bcd_conv_seq_if.slave    bus
);
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int BCD_W = 4 * DIGITS;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t              state, state_nxt;
   logic [DATA_W-1:0]   bin;
   logic [BCD_W-1:0]    scratch;
   logic [BCD_W-1:0]    adj;
   logic [BCD_W-1:0]    scratch_nxt;
   logic                carry;
   logic                sticky;
   logic [CNT_W-1:0]    cnt;
   logic                last_shift;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      bus.in_ready = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nxt = SHIFT;
         end
         SHIFT: if (last_shift)    state_nxt = DONE;
         DONE:  if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign last_shift = (cnt == CNT_W'(1));

   // All digits corrected in parallel, then the whole {scratch,bin} chain shifts by one.
   always_comb begin
      logic [3:0] d;
      adj = '0;
      d   = '0;
      for (int k = 0; k < DIGITS; k++) begin
         d = scratch[4*k +: 4];
         adj[4*k +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
      end
   end

   assign scratch_nxt = {adj[BCD_W-2:0], bin[DATA_W-1]};
   assign carry       = adj[BCD_W-1];

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         bin           <= '0;
         scratch       <= '0;
         sticky        <= 1'b0;
         cnt           <= '0;
         bus.out_valid <= 1'b0;
         bus.out_bcd   <= '0;
         bus.out_ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               bin     <= bus.in_data;
               scratch <= '0;
               sticky  <= 1'b0;
               cnt     <= CNT_W'(DATA_W);
            end
            SHIFT: begin
               bin     <= bin << 1;
               scratch <= scratch_nxt;
               sticky  <= sticky | carry;
               cnt     <= cnt - CNT_W'(1);
               if (last_shift) begin
                  bus.out_bcd   <= scratch_nxt;
                  bus.out_ovf   <= sticky | carry;
                  bus.out_valid <= 1'b1;
               end
            end
            DONE: if (bus.out_ready) bus.out_valid <= 1'b0;
            default: ;
         endcase
      end
   end

`ifdef BCD_BLANK_EN
   logic [DIGITS-1:0] blank_nxt;

   // Digit 0 is never blanked so a zero value still shows a single "0".
   always_comb begin
      logic zero_above;
      blank_nxt  = '0;
      zero_above = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         zero_above   = zero_above & (scratch_nxt[4*k +: 4] == 4'd0);
         blank_nxt[k] = zero_above;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)                           bus.out_blank <= '0;
      else if (state == SHIFT && last_shift) bus.out_blank <= blank_nxt;
   end
`endif
endmodule

// File: tb/tb_bcd_conv_seq.sv
// Randomized self-checking bench for bcd_conv_seq against an arithmetic decimal model.
module tb_bcd_conv_seq;
   localparam int DATA_W = 20;
   localparam int DIGITS = 6;
   localparam int unsigned MODV = 1000000;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   always #10 sys_clk = ~sys_clk;

   bcd_conv_seq_if #(.DATA_W(DATA_W), .DIGITS(DIGITS)) bus ();

   bcd_conv_seq #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_bcd(input int unsigned v);
      int unsigned r;
      logic [31:0] b;
      r = v % MODV;
      b = '0;
      for (int k = 0; k < DIGITS; k++) begin
         b[4*k +: 4] = 4'(r % 10);
         r = r / 10;
      end
      return b;
   endfunction

   function automatic logic [31:0] ref_blank(input int unsigned v);
      int unsigned r, p;
      logic [31:0] b;
      r = v % MODV;
      b = '0;
      p = 10;
      for (int k = 1; k < DIGITS; k++) begin
         b[k] = (r < p);
         p = p * 10;
      end
      return b;
   endfunction

   // Called #1 after a rising edge; returns at the same phase with in_ready high.
   task automatic wait_ready();
      int n;
      n = 0;
      while (!bus.in_ready && n < 100) begin
         @(posedge sys_clk); #1;
         n++;
      end
      if (!bus.in_ready) chk("ready_timeout", 32'(bus.in_ready), 32'd1);
   endtask

   task automatic convert(input int unsigned v, input int stall);
      int lat;
      logic [31:0] exp_bcd;
      exp_bcd = ref_bcd(v);
      wait_ready();
      bus.in_valid = 1'b1;
      bus.in_data  = DATA_W'(v);
      @(posedge sys_clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         @(posedge sys_clk); #1;
         lat++;
      end
      chk("latency", 32'(lat), 32'(DATA_W));
      chk("bcd", 32'(bus.out_bcd), exp_bcd);
      chk("ovf", 32'(bus.out_ovf), 32'(v >= MODV));
`ifdef BCD_BLANK_EN
      chk("blank", 32'(bus.out_blank), ref_blank(v));
`endif
      if (stall > 0) begin
         bus.in_valid = 1'b1;
         bus.in_data  = DATA_W'(777);
         repeat (stall) begin
            @(posedge sys_clk); #1;
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
         end
         chk("hold_bcd", 32'(bus.out_bcd), exp_bcd);
         bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'b1;
      @(posedge sys_clk); #1;
      bus.out_ready = 1'b0;
      chk("valid_drop", 32'(bus.out_valid), 32'd0);
      chk("ready_rise", 32'(bus.in_ready), 32'd1);
      chk("bcd_kept", 32'(bus.out_bcd), exp_bcd);
   endtask

   initial begin
      int cyc, got, acc, t0, t1;
      logic pre_ready, seen;
      logic [31:0] r0, r1;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      #25;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_bcd", 32'(bus.out_bcd), 32'd0);
      chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
`ifdef BCD_BLANK_EN
      chk("rst_out_blank", 32'(bus.out_blank), 32'd0);
`endif
      @(negedge sys_clk); sys_rst = 1'b0;
      @(posedge sys_clk); #1;

      convert(123456, 0);
      convert(1048575, 0);
      convert(999999, 0);
      convert(0, 0);
      convert(1000000, 0);
      convert(42, 0);
      convert(100000, 0);
      convert(314159, 10);

      // Back-to-back with out_ready held high.
      wait_ready();
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = DATA_W'(654321);
      cyc = 0; got = 0; acc = 0; t0 = 0; t1 = 0; r0 = '0; r1 = '0;
      while (got < 2 && cyc < 200) begin
         pre_ready = bus.in_ready;
         @(posedge sys_clk); #1;
         cyc++;
         if (pre_ready && bus.in_valid) begin
            acc++;
            if (acc == 1) bus.in_data = DATA_W'(987654);
            else          bus.in_valid = 1'b0;
         end
         if (bus.out_valid) begin
            if (got == 0) begin t0 = cyc; r0 = 32'(bus.out_bcd); end
            else          begin t1 = cyc; r1 = 32'(bus.out_bcd); end
            got++;
         end
      end
      chk("b2b_count", 32'(got), 32'd2);
      chk("b2b_first", r0, 32'h654321);
      chk("b2b_second", r1, 32'h987654);
      chk("b2b_gap", 32'(t1 - t0), 32'(DATA_W + 2));
      @(posedge sys_clk); #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;

      // Reset in the middle of a conversion.
      wait_ready();
      bus.in_valid = 1'b1;
      bus.in_data  = DATA_W'(555555);
      @(posedge sys_clk); #1;
      bus.in_valid = 1'b0;
      repeat (7) @(posedge sys_clk);
      #1 sys_rst = 1'b1;
      #1;
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("midrst_out_bcd", 32'(bus.out_bcd), 32'd0);
      @(negedge sys_clk); sys_rst = 1'b0;
      seen = 1'b0;
      repeat (30) begin
         @(posedge sys_clk); #1;
         if (bus.out_valid) seen = 1'b1;
      end
      chk("midrst_no_result", 32'(seen), 32'd0);
      convert(42, 0);

      for (int i = 0; i < 16; i++)
         convert($urandom_range(0, (1 << DATA_W) - 1), $urandom_range(0, 3));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
